// File: rtl/eth_rx_frame_tracker_if.sv
// Stream-in, stream-out and length-descriptor signals of the RX frame tracker.
`timescale 1ns/1ps
interface eth_rx_frame_tracker_if #(
  parameter int DataWidth    = 32,
  parameter int LenWidth     = 16,
  parameter int LenFifoDepth = 4
);
  logic                              s_tvalid_i;
  logic                              s_tready_o;
  logic [DataWidth-1:0]              s_tdata_i;
  logic [DataWidth/8-1:0]            s_tkeep_i;
  logic                              s_tlast_i;
  logic                              m_tvalid_o;
  logic                              m_tready_i;
  logic [DataWidth-1:0]              m_tdata_o;
  logic [DataWidth/8-1:0]            m_tkeep_o;
  logic                              m_tlast_o;
  logic                              len_valid_o;
  logic                              len_ready_i;
  logic [LenWidth-1:0]               len_o;
  logic                              len_oversize_o;
  logic [$clog2(LenFifoDepth):0]     len_count_o;
  logic                              in_frame_o;

  modport master (
    output s_tvalid_i, s_tdata_i, s_tkeep_i, s_tlast_i, m_tready_i, len_ready_i,
    input  s_tready_o, m_tvalid_o, m_tdata_o, m_tkeep_o, m_tlast_o,
           len_valid_o, len_o, len_oversize_o, len_count_o, in_frame_o
  );

  modport slave (
    input  s_tvalid_i, s_tdata_i, s_tkeep_i, s_tlast_i, m_tready_i, len_ready_i,
    output s_tready_o, m_tvalid_o, m_tdata_o, m_tkeep_o, m_tlast_o,
           len_valid_o, len_o, len_oversize_o, len_count_o, in_frame_o
  );
endinterface

// File: rtl/eth_rx_frame_tracker.sv
// Forwards RX AXI-Stream through one register stage (1-cycle latency) and queues a byte-length descriptor per frame.
// Ready follows the output stage; a tlast beat additionally stalls while the length FIFO is full and not being popped.
`timescale 1ns/1ps
module eth_rx_frame_tracker #(
  parameter int DataWidth     = 32,
  parameter int LenWidth      = 16,
  parameter int LenFifoDepth  = 4,
  parameter int MaxFrameBytes = 1518
) (
  input logic                   clk_i,
  input logic                   rst_i,
  eth_rx_frame_tracker_if.slave bus
);
  localparam int KeepW = DataWidth / 8;
  localparam int BbW   = $clog2(KeepW) + 1;
  localparam int PtrW  = $clog2(LenFifoDepth);
  localparam int CntW  = PtrW + 1;
  localparam logic [CntW-1:0]   DEPTH_C = CntW'(LenFifoDepth);
  localparam logic [LenWidth:0] MAX_C   = (LenWidth+1)'(MaxFrameBytes);

  typedef struct packed {
    logic                oversize;
    logic [LenWidth-1:0] len;
  } desc_t;

  logic                 r_m_vld;
  logic [DataWidth-1:0] r_m_dat;
  logic [KeepW-1:0]     r_m_keep;
  logic                 r_m_last;
  logic [LenWidth-1:0]  r_cnt;
  logic                 r_ovr;
  logic                 r_in_frame;
  desc_t                r_fifo [LenFifoDepth];
  logic [PtrW-1:0]      r_wr_ptr;
  logic [PtrW-1:0]      r_rd_ptr;
  logic [CntW-1:0]      r_count;

  logic                 w_len_vld;
  logic                 w_has_space;
  logic                 w_s_rdy;
  logic                 w_acc;
  logic                 w_push;
  logic                 w_pop;
  logic [BbW-1:0]       w_beat_bytes;
  logic [LenWidth:0]    w_sum;
  logic                 w_sat;
  logic [LenWidth-1:0]  w_len;
  logic                 w_ovr;

  // A push into a full FIFO is fine when the head is popped on the same edge.
  assign w_len_vld   = (r_count != '0);
  assign w_has_space = (r_count < DEPTH_C) || bus.len_ready_i;
  assign w_s_rdy     = (!r_m_vld || bus.m_tready_i) && (!bus.s_tlast_i || w_has_space);
  assign w_acc       = bus.s_tvalid_i && w_s_rdy;
  assign w_push      = w_acc && bus.s_tlast_i;
  assign w_pop       = w_len_vld && bus.len_ready_i;

  always_comb begin
    w_beat_bytes = '0;
    for (int i = 0; i < KeepW; i++) begin
      w_beat_bytes = w_beat_bytes + BbW'(bus.s_tkeep_i[i]);
    end
  end

  assign w_sum = {1'b0, r_cnt} + (LenWidth+1)'(w_beat_bytes);
  assign w_sat = w_sum[LenWidth];
  assign w_len = w_sat ? '1 : w_sum[LenWidth-1:0];
  assign w_ovr = r_ovr || w_sat || (w_sum > MAX_C);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_m_vld    <= 1'b0;
      r_m_dat    <= '0;
      r_m_keep   <= '0;
      r_m_last   <= 1'b0;
      r_cnt      <= '0;
      r_ovr      <= 1'b0;
      r_in_frame <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
    end else begin
      if (w_acc) begin
        r_m_vld  <= 1'b1;
        r_m_dat  <= bus.s_tdata_i;
        r_m_keep <= bus.s_tkeep_i;
        r_m_last <= bus.s_tlast_i;
        if (bus.s_tlast_i) begin
          r_cnt      <= '0;
          r_ovr      <= 1'b0;
          r_in_frame <= 1'b0;
        end else begin
          r_cnt      <= w_len;
          r_ovr      <= w_ovr;
          r_in_frame <= 1'b1;
        end
      end else if (bus.m_tready_i) begin
        r_m_vld <= 1'b0;
      end

      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Descriptor storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge clk_i) begin
    if (w_push) r_fifo[r_wr_ptr] <= '{oversize: w_ovr, len: w_len};
  end

  assign bus.s_tready_o     = w_s_rdy;
  assign bus.m_tvalid_o     = r_m_vld;
  assign bus.m_tdata_o      = r_m_dat;
  assign bus.m_tkeep_o      = r_m_keep;
  assign bus.m_tlast_o      = r_m_last;
  assign bus.len_valid_o    = w_len_vld;
  assign bus.len_o          = r_fifo[r_rd_ptr].len;
  assign bus.len_oversize_o = r_fifo[r_rd_ptr].oversize;
  assign bus.len_count_o    = r_count;
  assign bus.in_frame_o     = r_in_frame;
endmodule

// File: tb/tb_eth_rx_frame_tracker.sv
// Directed bench for eth_rx_frame_tracker with a frame-level reference model checked every cycle.
`timescale 1ns/1ps
module tb_eth_rx_frame_tracker;
  localparam int DW    = 32;
  localparam int LW    = 16;
  localparam int DEPTH = 4;
  localparam int MAXB  = 1518;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  eth_rx_frame_tracker_if #(.DataWidth(DW), .LenWidth(LW), .LenFifoDepth(DEPTH)) bus ();

  eth_rx_frame_tracker #(
    .DataWidth(DW), .LenWidth(LW), .LenFifoDepth(DEPTH), .MaxFrameBytes(MAXB)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: frame byte totals, a descriptor queue and the single held beat.
  typedef struct {
    int len;
    bit ov;
  } desc_t;

  desc_t           lq[$];
  bit              mv = 0;
  logic [DW-1:0]   md = '0;
  logic [DW/8-1:0] mk = '0;
  logic            ml = 0;
  int              total = 0;
  bit              inf = 0;
  bit              mdl_acc = 0;

  always @(negedge clk) begin
    bit    exp_rdy;
    bit    acc;
    desc_t d;
    chk("m_tvalid", bus.m_tvalid_o, mv);
    if (mv) begin
      chk("m_tdata", bus.m_tdata_o, md);
      chk("m_tkeep", bus.m_tkeep_o, mk);
      chk("m_tlast", bus.m_tlast_o, ml);
    end
    chk("len_valid", bus.len_valid_o, lq.size() != 0);
    if (lq.size() != 0) begin
      chk("len", bus.len_o, lq[0].len);
      chk("len_oversize", bus.len_oversize_o, lq[0].ov);
    end
    chk("len_count", bus.len_count_o, lq.size());
    chk("in_frame", bus.in_frame_o, inf);
    exp_rdy = (!mv || bus.m_tready_i) && (!bus.s_tlast_i || lq.size() < DEPTH || bus.len_ready_i);
    chk("s_tready", bus.s_tready_o, exp_rdy);

    if (rst) begin
      lq.delete();
      mv = 0; md = '0; mk = '0; ml = 0;
      total = 0; inf = 0; mdl_acc = 0;
    end else begin
      acc = bus.s_tvalid_i && exp_rdy;
      if (lq.size() != 0 && bus.len_ready_i) void'(lq.pop_front());
      if (acc) begin
        mv = 1; md = bus.s_tdata_i; mk = bus.s_tkeep_i; ml = bus.s_tlast_i;
        total += $countones(bus.s_tkeep_i);
        if (bus.s_tlast_i) begin
          d.len = (total > 65535) ? 65535 : total;
          d.ov  = (total > MAXB);
          lq.push_back(d);
          total = 0;
          inf = 0;
        end else begin
          inf = 1;
        end
      end else if (bus.m_tready_i) begin
        mv = 0;
      end
      mdl_acc = acc;
    end
  end

  bit rnd_mode = 0;
  bit fix_rdy  = 1;
  always @(posedge clk) begin
    #1;
    bus.m_tready_i = rnd_mode ? 1'($urandom_range(0, 1)) : fix_rdy;
  end

  task automatic send_beat(input logic [DW-1:0] d, input logic [DW/8-1:0] k, input logic l);
    int n   = 0;
    bit got = 0;
    bus.s_tvalid_i = 1'b1;
    bus.s_tdata_i  = d;
    bus.s_tkeep_i  = k;
    bus.s_tlast_i  = l;
    while (!got && n < 200) begin
      @(posedge clk);
      got = mdl_acc;
      n++;
      #1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: beat %0h not accepted within 200 cycles", d);
    end
    bus.s_tvalid_i = 1'b0;
    bus.s_tlast_i  = 1'b0;
  endtask

  task automatic send_frame(input int beats, input logic [DW/8-1:0] last_keep, input int tag);
    for (int i = 0; i < beats; i++)
      send_beat(DW'(tag * 1000 + i), (i == beats - 1) ? last_keep : 4'hF, i == beats - 1);
  endtask

  task automatic pop_check(input int l, input bit ov, input string nm);
    chk({nm, "_vld"}, bus.len_valid_o, 1);
    chk(nm, bus.len_o, l);
    chk({nm, "_ov"}, bus.len_oversize_o, ov);
    bus.len_ready_i = 1'b1;
    @(posedge clk);
    #1;
    bus.len_ready_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [3:0] keeps [5];
    keeps = '{4'h1, 4'h3, 4'h7, 4'hF, 4'h1};
    rst = 1'b1;
    bus.s_tvalid_i = 1'b0; bus.s_tdata_i = '0; bus.s_tkeep_i = '0; bus.s_tlast_i = 1'b0;
    bus.len_ready_i = 1'b0;
    idle(3);
    chk("rst_m_tvalid", bus.m_tvalid_o, 0);
    chk("rst_len_valid", bus.len_valid_o, 0);
    chk("rst_len_count", bus.len_count_o, 0);
    chk("rst_in_frame", bus.in_frame_o, 0);
    rst = 1'b0;
    idle(1);

    // 64-byte frame
    send_frame(16, 4'hF, 1);
    chk("f64_count", bus.len_count_o, 1);
    idle(2);
    chk("f64_count_hold", bus.len_count_o, 1);
    pop_check(64, 0, "f64_len");

    // 10, 1 and 0-byte frames
    send_frame(3, 4'h3, 2);
    send_frame(1, 4'h1, 3);
    send_frame(1, 4'h0, 4);
    idle(1);
    chk("three_count", bus.len_count_o, 3);
    pop_check(10, 0, "len10");
    pop_check(1, 0, "len1");
    pop_check(0, 0, "len0");

    // oversize then normal frame
    send_frame(380, 4'h7, 5);
    pop_check(1519, 1, "len1519");
    send_frame(15, 4'hF, 6);
    pop_check(60, 0, "len60");

    // fill the descriptor FIFO, fifth tlast must wait for a pop
    for (int i = 0; i < 4; i++) send_frame(1, keeps[i], 10 + i);
    bus.s_tvalid_i = 1'b1; bus.s_tdata_i = 32'hF1F0; bus.s_tkeep_i = keeps[4]; bus.s_tlast_i = 1'b1;
    idle(2);
    chk("full_stall_rdy", bus.s_tready_o, 0);
    chk("full_count", bus.len_count_o, 4);
    bus.len_ready_i = 1'b1;
    #1;
    chk("full_pop_rdy", bus.s_tready_o, 1);
    chk("full_head", bus.len_o, 1);
    @(posedge clk);
    #1;
    bus.s_tvalid_i = 1'b0; bus.s_tlast_i = 1'b0; bus.len_ready_i = 1'b0;
    chk("full_count_after", bus.len_count_o, 4);
    pop_check(2, 0, "fifo_len2");
    pop_check(3, 0, "fifo_len3");
    pop_check(4, 0, "fifo_len4");
    pop_check(1, 0, "fifo_len1");

    // random downstream backpressure over 20 frames
    rnd_mode = 1'b1;
    bus.len_ready_i = 1'b1;
    for (int f = 0; f < 20; f++) send_frame((f % 4) + 1, keeps[f % 5], 20 + f);
    rnd_mode = 1'b0;
    idle(4);
    chk("rnd_drained", bus.len_count_o, 0);
    bus.len_ready_i = 1'b0;

    // reset mid-frame with descriptors queued
    send_frame(1, 4'hF, 50);
    send_frame(1, 4'h3, 51);
    for (int i = 0; i < 7; i++) send_beat(DW'(5200 + i), 4'hF, 1'b0);
    chk("pre_rst_in_frame", bus.in_frame_o, 1);
    chk("pre_rst_count", bus.len_count_o, 2);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("mid_rst_m_tvalid", bus.m_tvalid_o, 0);
    chk("mid_rst_len_valid", bus.len_valid_o, 0);
    chk("mid_rst_in_frame", bus.in_frame_o, 0);
    send_frame(2, 4'hF, 53);
    pop_check(8, 0, "post_rst_len8");
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
